// File: rtl/seletor_escrita_pipeline_if.sv
// Decode-side bundle for seletor_escrita_pipeline.
//   slave  : the selector/scoreboard itself (takes decode fields, returns
//            destination, write-back strobe, stall and pending count)
//   master : the controller/decoder side driving it
interface seletor_escrita_pipeline_if #(
  parameter int LARGURA_END  = 5,
  parameter int PROFUNDIDADE = 2
);
  localparam int LARGURA_PEND = $clog2(PROFUNDIDADE + 1);

  logic [LARGURA_END-1:0]  endereco_2;        // rt field
  logic [LARGURA_END-1:0]  endereco_3;        // rd field
  logic [1:0]              mux_REGISTRADOR;   // 0 none, 1 rt, 2 rd, 3 link reg
  logic                    valido;            // instruction in decode
  logic                    descarta;          // flush in-flight writes
  logic [LARGURA_END-1:0]  end_leitura_1;     // rs source
  logic [LARGURA_END-1:0]  end_leitura_2;     // rt source
  logic [LARGURA_END-1:0]  endereco_escrita;  // selected destination (comb)
  logic [LARGURA_END-1:0]  end_escrita_wb;    // destination at write-back
  logic                    escrita_wb;        // register-file write enable
  logic                    bloqueio;          // stall request
  logic [LARGURA_PEND-1:0] num_pendentes;     // valid in-flight writes

  modport slave (
    input  endereco_2, endereco_3, mux_REGISTRADOR, valido, descarta,
           end_leitura_1, end_leitura_2,
    output endereco_escrita, end_escrita_wb, escrita_wb, bloqueio, num_pendentes
  );

  modport master (
    output endereco_2, endereco_3, mux_REGISTRADOR, valido, descarta,
           end_leitura_1, end_leitura_2,
    input  endereco_escrita, end_escrita_wb, escrita_wb, bloqueio, num_pendentes
  );
endinterface

// File: rtl/seletor_escrita_pipeline.sv
// Write-register selector with destination pipeline and hazard scoreboard.
// Picks the destination (none / rt / rd / link register), carries it through
// PROFUNDIDADE stages to write-back, and stalls decode while a source register
// still has a write in flight.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : decode fields in; endereco_escrita, end_escrita_wb,
//                  escrita_wb, bloqueio, num_pendentes out
module seletor_escrita_pipeline #(
  parameter int LARGURA_END  = 5,
  parameter int PROFUNDIDADE = 2,   // 1..8
  parameter int END_RETORNO  = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  seletor_escrita_pipeline_if.slave bus
);
  localparam int LP = $clog2(PROFUNDIDADE + 1);

  logic [PROFUNDIDADE-1:0]                  vld_pipe;
  logic [PROFUNDIDADE-1:0][LARGURA_END-1:0] end_pipe;
  logic [PROFUNDIDADE-1:0]                  hit;
  logic [LARGURA_END-1:0]                   sel;
  logic [LP-1:0]                            pend;
  logic                                     emite, grava;

  always_comb begin
    sel = '0;
    unique case (bus.mux_REGISTRADOR)
      2'd0: sel = '0;
      2'd1: sel = bus.endereco_2;
      2'd2: sel = bus.endereco_3;
      2'd3: sel = LARGURA_END'(END_RETORNO);
    endcase
  end

  // Every stage, write-back included, is a hazard source: there is no
  // bypass into the register-file read, so the reader waits until the
  // write-back cycle has passed. Source 0 is hard-wired and never stalls.
  for (genvar k = 0; k < PROFUNDIDADE; k++) begin : g_cmp
    assign hit[k] = vld_pipe[k] &
                    (((bus.end_leitura_1 != '0) && (end_pipe[k] == bus.end_leitura_1)) ||
                     ((bus.end_leitura_2 != '0) && (end_pipe[k] == bus.end_leitura_2)));
  end

  assign bus.bloqueio = bus.valido & (|hit);
  assign emite        = bus.valido & ~bus.bloqueio & ~bus.descarta;
  // Writes to $zero (or code 0) enter the pipe as bubbles.
  assign grava        = emite && (bus.mux_REGISTRADOR != 2'd0) && (sel != '0);

  always_ff @(posedge clock) begin
    if (reset || bus.descarta) begin
      vld_pipe <= '0;
      end_pipe <= '0;
    end else begin
      vld_pipe[0] <= grava;
      end_pipe[0] <= grava ? sel : '0;
      for (int k = 1; k < PROFUNDIDADE; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        end_pipe[k] <= end_pipe[k-1];
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int k = 0; k < PROFUNDIDADE; k++) pend = pend + LP'(vld_pipe[k]);
  end

  assign bus.endereco_escrita = sel;
  assign bus.end_escrita_wb   = end_pipe[PROFUNDIDADE-1];
  assign bus.escrita_wb       = vld_pipe[PROFUNDIDADE-1];
  assign bus.num_pendentes    = pend;
endmodule

// File: tb/tb_seletor_escrita_pipeline.sv
module tb_seletor_escrita_pipeline;
  localparam int LW = 5;
  localparam int P  = 2;
  localparam int RA = 31;

  typedef struct { int sel; int bloq; int pend; int wb; int wba; } exp_t;
  typedef struct { int a; int c; } wr_t;

  bit clk = 1'b0;
  logic reset;
  int cyc = 0;
  int total = 0, bad = 0;

  exp_t expq[$];
  wr_t  wbq[$];       // expected write-backs, popped by the monitor
  wr_t  inflight[$];  // reference model: issued writes with their write-back cycle

  seletor_escrita_pipeline_if #(.LARGURA_END(LW), .PROFUNDIDADE(P)) bus ();

  seletor_escrita_pipeline #(.LARGURA_END(LW), .PROFUNDIDADE(P), .END_RETORNO(RA)) dut (
    .clock(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: pops expectations at the falling edge, decoupled from the driver.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      cmp("endereco_escrita", int'(bus.endereco_escrita), e.sel);
      cmp("bloqueio", int'(bus.bloqueio), e.bloq);
      cmp("num_pendentes", int'(bus.num_pendentes), e.pend);
      cmp("escrita_wb", int'(bus.escrita_wb), e.wb);
    end
    if (bus.escrita_wb === 1'b1) begin
      if (wbq.size() == 0) cmp("wb_unexpected", 1, 0);
      else begin
        wr_t w;
        w = wbq.pop_front();
        cmp("wb_addr", int'(bus.end_escrita_wb), w.a);
        cmp("wb_cycle", cyc, w.c);
      end
    end else if (wbq.size() > 0 && wbq[0].c <= cyc) begin
      cmp("wb_missing", 0, wbq[0].a);
      void'(wbq.pop_front());
    end
  end

  // One decode cycle: drive inputs, predict outputs, then update the model at the edge.
  task automatic step(bit rs, bit v, bit d, int code, int rt, int rd, int s1, int s2);
    exp_t e;
    int c, sel;
    bit flag;
    c = cyc;
    reset = rs;
    bus.valido = v; bus.descarta = d;
    bus.mux_REGISTRADOR = 2'(code);
    bus.endereco_2 = LW'(rt); bus.endereco_3 = LW'(rd);
    bus.end_leitura_1 = LW'(s1); bus.end_leitura_2 = LW'(s2);
    case (code)
      0: sel = 0;
      1: sel = rt;
      2: sel = rd;
      default: sel = RA;
    endcase
    flag = (code != 0) && (sel != 0);
    while (inflight.size() > 0 && inflight[0].c < c) void'(inflight.pop_front());
    e.sel = sel; e.pend = inflight.size(); e.bloq = 0; e.wb = 0; e.wba = 0;
    foreach (inflight[i]) begin
      if (inflight[i].c == c) begin e.wb = 1; e.wba = inflight[i].a; end
      if (v && ((s1 != 0 && inflight[i].a == s1) || (s2 != 0 && inflight[i].a == s2))) e.bloq = 1;
    end
    expq.push_back(e);
    @(posedge clk);
    if (rs || d) begin
      inflight.delete();
      for (int i = wbq.size() - 1; i >= 0; i--) if (wbq[i].c > c) wbq.delete(i);
    end else if (v && !e.bloq && flag) begin
      wr_t w;
      w.a = sel; w.c = c + P;
      inflight.push_back(w);
      wbq.push_back(w);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.valido = 1'b1; bus.descarta = 1'b0; bus.mux_REGISTRADOR = 2'd0;
    bus.endereco_2 = '0; bus.endereco_3 = '0;
    bus.end_leitura_1 = 5'd5; bus.end_leitura_2 = 5'd6;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, 0, 5, 6);                 // reset state
    for (int k = 0; k < 4; k++) step(0, 0, 0, k, 7, 9, 0, 0);  // selection codes
    step(0, 1, 0, 2, 0, 9, 0, 0);                 // single write to r9
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 9, 0, 0);                 // producer r9
    repeat (3) step(0, 1, 0, 2, 0, 12, 9, 0);     // dependent reader of r9
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);                 // write to $zero dropped
    step(0, 1, 0, 1, 0, 0, 0, 0);                 // read r0
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 3, 0, 0);                 // r3
    step(0, 1, 0, 2, 0, 4, 0, 0);                 // r4
    step(0, 1, 1, 2, 0, 5, 0, 0);                 // flush + r5
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(0, 1, 0, 2, 0, k, 0, 0);  // r1..r4 back-to-back
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0, 0, 0, 0);                 // link register, then reset mid-flight
    step(1, 1, 0, 2, 0, 8, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++)
      step(($urandom % 60) == 0, ($urandom % 10) < 8, ($urandom % 25) == 0,
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7));
    repeat (P + 3) step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    cmp("wbq_drained", wbq.size(), 0);
    cmp("expq_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seletor_escrita_pipeline.md
# seletor_escrita_pipeline

Parametrised successor to the processor's write-register address multiplexer. It selects the destination register (rt, rd, return register or none) and carries the destination through a configurable number of pipeline stages to write-back. It also keeps a scoreboard of in-flight writes and raises a stall when a decoding instruction reads a register that still has a write pending. It sits between the controller/decoder and the register file.

## Interface
- LARGURA_END, 5: width of register addresses.
- PROFUNDIDADE, 2: pipeline stages from issue to write-back; legal range 1 to 8.
- END_RETORNO, 31: destination address selected by code 3 (jal link register).

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- endereco_2  in  LARGURA_END  rt field.
- endereco_3  in  LARGURA_END  rd field.
- mux_REGISTRADOR  in  2  destination select from the controller: 0 none, 1 rt, 2 rd, 3 END_RETORNO.
- valido  in  1  an instruction is presented in decode this cycle.
- descarta  in  1  flush of all in-flight writes.
- end_leitura_1  in  LARGURA_END  rs source of the decoding instruction.
- end_leitura_2  in  LARGURA_END  rt source of the decoding instruction.
- endereco_escrita  out  LARGURA_END  combinational selected destination for the current instruction.
- end_escrita_wb  out  LARGURA_END  destination at write-back (registered).
- escrita_wb  out  1  register-file write enable at write-back (registered).
- bloqueio  out  1  stall request to the fetch/decode logic.
- num_pendentes  out  $clog2(PROFUNDIDADE+1)  count of valid in-flight writes.

## Operation
- Selection (combinational) drives endereco_escrita:
  - code 0: 0.
  - code 1: endereco_2.
  - code 2: endereco_3.
  - code 3: END_RETORNO.
  - No latch: every code assigns a value.
- Write flag of the selected entry: 1 only when code ≠ 0 and the selected address ≠ 0. Writes to $zero are dropped at issue.
- Issue: emite = valido & ~bloqueio & ~descarta. The issued entry is {address, flag}.
- Pipeline: PROFUNDIDADE stages of {valid, address}, shifting every cycle.
  - Stage 0 loads the issued entry when emite = 1, otherwise a bubble (valid = 0, address = 0).
  - The last stage drives end_escrita_wb and escrita_wb.
  - An issued entry with flag 0 travels as a bubble.
- Scoreboard: bloqueio = valido & ∃ stage k with valid_k & (addr_k == end_leitura_1 | addr_k == end_leitura_2).
  - Source address 0 never matches.
  - All stages, including the write-back stage, are compared. There is no write-through.
- num_pendentes = population count of stage valid bits.
- descarta: on the next edge all stage valid bits clear and addresses go to 0.
  - The current write-back entry still completes this cycle, because its outputs are already registered.
  - descarta has priority over a simultaneous issue; the issue is dropped.
- reset has priority over descarta and over issue.

## Timing
- Reset values: end_escrita_wb = 0, escrita_wb = 0, num_pendentes = 0, bloqueio = 0 (it depends on valid bits, which are all clear). endereco_escrita follows its inputs.
- Latency: an entry issued at edge n appears on end_escrita_wb/escrita_wb after edge n+PROFUNDIDADE, for exactly one cycle.
- Throughput: one issue per cycle when there is no hazard.
- Stall length: a dependent instruction stalls for PROFUNDIDADE cycles after the producer issues, then issues on the cycle after the producer's write-back cycle.
- bloqueio and endereco_escrita are combinational from the inputs and the registers. All other outputs are registered.
- Reset asserted mid-operation: the next edge clears everything, and in-flight writes are lost.

## Test plan
- PROFUNDIDADE=2:
  - Reset with valido=1 and sources 5/6 → escrita_wb=0, bloqueio=0, num_pendentes=0.
  - Codes 0/1/2/3 with rt=7, rd=9 → endereco_escrita = 0/7/9/31.
- Issue code 2 with rd=9 at cycle 0 and nothing after it → escrita_wb=1 with end_escrita_wb=9 only in cycle 2; num_pendentes goes 1, 1, 0.
- Issue a write to r9, then present end_leitura_1=9 → bloqueio=1 for 2 cycles; the dependent instruction issues in cycle 3; no entry is added during the stall.
- Issue code 1 with rt=0, then read r0 → escrita_wb never rises and bloqueio stays 0.
- Issue writes to r3 and r4 back-to-back, then assert descarta together with a new issue to r5 → r3 writes back, r4 and r5 never do, and num_pendentes=0 after the edge.
- Back-to-back independent writes to r1 through r4 → 4 consecutive write-back cycles in order, and bloqueio stays 0.
